// File: rtl/basket_manager_pkg.sv
// Shared defaults and state encodings for the basket manager and its price summer.
package basket_manager_pkg;

  localparam int unsigned DefMaxItems = 12;
  localparam int unsigned DefIdW      = 4;
  localparam int unsigned DefQtyW     = 4;
  localparam int unsigned DefMaxQty   = 9;
  localparam int unsigned DefPriceW   = 8;
  localparam int unsigned DefTotalW   = 16;

  // Command sequencer states; the summing pass runs inside the summer while in StSum.
  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StUpdate,
    StShift,
    StSum
  } bm_state_e;

  // Summer states: one address cycle then one accumulate cycle per entry.
  typedef enum logic [1:0] {
    SumIdle,
    SumAddr,
    SumAcc
  } sum_state_e;

  typedef enum logic {
    OpAdd,
    OpRemove
  } bm_op_e;

endpackage

// File: rtl/basket_price_summer.sv
// Walks basket entries 0..count-1, fetching each price and accumulating qty*price.
module basket_price_summer
  import basket_manager_pkg::*;
#(
  parameter int unsigned ID_W    = DefIdW,
  parameter int unsigned QTY_W   = DefQtyW,
  parameter int unsigned PRICE_W = DefPriceW,
  parameter int unsigned TOTAL_W = DefTotalW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [ID_W-1:0]    count_i,
  output logic [ID_W-1:0]    ent_idx_o,
  input  logic [ID_W-1:0]    ent_id_i,
  input  logic [QTY_W-1:0]   ent_qty_i,
  output logic [ID_W-1:0]    price_addr_o,
  input  logic [PRICE_W-1:0] price_data_i,
  output logic               done_o,
  output logic [TOTAL_W-1:0] sum_o
);

  sum_state_e                 state_q, state_d;
  logic [ID_W-1:0]            idx_q, idx_d;
  logic [TOTAL_W-1:0]         acc_q, acc_d;
  logic [QTY_W+PRICE_W-1:0]   prod;

  assign ent_idx_o = idx_q;
  assign prod      = (QTY_W + PRICE_W)'(ent_qty_i) * (QTY_W + PRICE_W)'(price_data_i);

  // Sequencer state, entry index and accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SumIdle;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state, ROM address and completion; the ROM answers in the cycle after the address.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    done_o       = 1'b0;
    sum_o        = acc_q;
    price_addr_o = '0;
    unique case (state_q)
      SumIdle: begin
        if (start_i) begin
          state_d = SumAddr;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      SumAddr: begin
        if (count_i == '0) begin
          // Empty basket: finish with zero and never touch the ROM.
          done_o  = 1'b1;
          sum_o   = '0;
          state_d = SumIdle;
        end else begin
          price_addr_o = ent_id_i;
          state_d      = SumAcc;
        end
      end
      SumAcc: begin
        sum_o = acc_q + TOTAL_W'(prod);
        acc_d = sum_o;
        if (idx_q == count_i - 1'b1) begin
          done_o  = 1'b1;
          state_d = SumIdle;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SumAddr;
        end
      end
      default: state_d = SumIdle;
    endcase
  end

endmodule

// File: rtl/basket_manager.sv
// Basket contents store: add/remove/clear commands, list compaction and total recomputation.
module basket_manager
  import basket_manager_pkg::*;
#(
  parameter int unsigned MAX_ITEMS = DefMaxItems,
  parameter int unsigned ID_W      = DefIdW,
  parameter int unsigned QTY_W     = DefQtyW,
  parameter int unsigned MAX_QTY   = DefMaxQty,
  parameter int unsigned PRICE_W   = DefPriceW,
  parameter int unsigned TOTAL_W   = DefTotalW
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               Enable,
  input  logic               AddReq,
  input  logic               RemoveReq,
  input  logic               ClearReq,
  input  logic [ID_W-1:0]    SelProductID,
  input  logic [ID_W-1:0]    SelBasketIdx,
  input  logic [ID_W-1:0]    RdIdx,
  input  logic [PRICE_W-1:0] PriceData,
  output logic [ID_W-1:0]    PriceAddr,
  output logic [ID_W-1:0]    RdProductID,
  output logic [QTY_W-1:0]   RdQty,
  output logic [ID_W-1:0]    BasketProductNum,
  output logic               BasketEmpty,
  output logic [TOTAL_W-1:0] Total,
  output logic               Busy,
  output logic               Ack,
  output logic               Nack
);

  localparam logic [ID_W-1:0]  MaxItemsL = ID_W'(MAX_ITEMS);
  localparam logic [QTY_W-1:0] MaxQtyL   = QTY_W'(MAX_QTY);

  bm_state_e          state_q, state_d;
  bm_op_e             op_q, op_d;
  logic [ID_W-1:0]    id_q  [MAX_ITEMS];
  logic [ID_W-1:0]    id_d  [MAX_ITEMS];
  logic [QTY_W-1:0]   qty_q [MAX_ITEMS];
  logic [QTY_W-1:0]   qty_d [MAX_ITEMS];
  logic [ID_W-1:0]    count_q, count_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    sel_id_q, sel_id_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               ack_q, ack_d, nack_q, nack_d;
  logic [ID_W-1:0]    rd_id_q, rd_id_d;
  logic [QTY_W-1:0]   rd_qty_q, rd_qty_d;

  logic               sum_start, sum_done;
  logic [TOTAL_W-1:0] sum_val;
  logic [ID_W-1:0]    sum_idx;
  logic [ID_W-1:0]    count_m1, ptr_nx;

  assign count_m1         = count_q - 1'b1;
  assign ptr_nx           = ptr_q + 1'b1;
  assign BasketEmpty      = (count_q == '0);
  assign BasketProductNum = BasketEmpty ? '0 : count_m1;
  assign Total            = total_q;
  assign Busy             = (state_q != StIdle);
  assign Ack              = ack_q;
  assign Nack             = nack_q;
  assign RdProductID      = rd_id_q;
  assign RdQty            = rd_qty_q;

  basket_price_summer #(
    .ID_W    (ID_W),
    .QTY_W   (QTY_W),
    .PRICE_W (PRICE_W),
    .TOTAL_W (TOTAL_W)
  ) u_summer (
    .clk_i        (CLOCK),
    .rst_ni       (RESET_N),
    .start_i      (sum_start),
    .count_i      (count_q),
    .ent_idx_o    (sum_idx),
    .ent_id_i     (id_q[sum_idx]),
    .ent_qty_i    (qty_q[sum_idx]),
    .price_addr_o (PriceAddr),
    .price_data_i (PriceData),
    .done_o       (sum_done),
    .sum_o        (sum_val)
  );

  // All architectural state; reset clears everything, including an operation in flight.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      count_q  <= '0;
      ptr_q    <= '0;
      sel_id_q <= '0;
      total_q  <= '0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      rd_id_q  <= '0;
      rd_qty_q <= '0;
      for (int i = 0; i < int'(MAX_ITEMS); i++) begin
        id_q[i]  <= '0;
        qty_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      sel_id_q <= sel_id_d;
      total_q  <= total_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      rd_id_q  <= rd_id_d;
      rd_qty_q <= rd_qty_d;
      for (int i = 0; i < int'(MAX_ITEMS); i++) begin
        id_q[i]  <= id_d[i];
        qty_q[i] <= qty_d[i];
      end
    end
  end

  // Display read port, independent of the command sequencer.
  always_comb begin
    rd_id_d  = '0;
    rd_qty_d = '0;
    if (RdIdx < count_q) begin
      rd_id_d  = id_q[RdIdx];
      rd_qty_d = qty_q[RdIdx];
    end
  end

  // Command sequencer: search, in-place update, compaction, then a summing pass.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    sel_id_d  = sel_id_q;
    total_d   = total_q;
    id_d      = id_q;
    qty_d     = qty_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    sum_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Enable) begin
          if (ClearReq) begin
            for (int i = 0; i < int'(MAX_ITEMS); i++) begin
              id_d[i]  = '0;
              qty_d[i] = '0;
            end
            count_d = '0;
            total_d = '0;
            ack_d   = 1'b1;
          end else if (RemoveReq) begin
            if (SelBasketIdx >= count_q) begin
              nack_d = 1'b1;
            end else begin
              ptr_d   = SelBasketIdx;
              op_d    = OpRemove;
              state_d = StUpdate;
            end
          end else if (AddReq) begin
            sel_id_d = SelProductID;
            ptr_d    = '0;
            op_d     = OpAdd;
            state_d  = StSearch;
          end
        end
      end
      StSearch: begin
        if ((count_q != '0) && (id_q[ptr_q] == sel_id_q)) begin
          if (qty_q[ptr_q] == MaxQtyL) begin
            nack_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StUpdate;
          end
        end else if ((count_q == '0) || (ptr_q == count_m1)) begin
          if (count_q == MaxItemsL) begin
            nack_d  = 1'b1;
            state_d = StIdle;
          end else begin
            id_d[count_q]  = sel_id_q;
            qty_d[count_q] = QTY_W'(1);
            count_d        = count_q + 1'b1;
            sum_start      = 1'b1;
            state_d        = StSum;
          end
        end else begin
          ptr_d = ptr_nx;
        end
      end
      StUpdate: begin
        if (op_q == OpAdd) begin
          qty_d[ptr_q] = qty_q[ptr_q] + 1'b1;
          sum_start    = 1'b1;
          state_d      = StSum;
        end else begin
          qty_d[ptr_q] = qty_q[ptr_q] - 1'b1;
          if (qty_q[ptr_q] == QTY_W'(1)) begin
            state_d = StShift;
          end else begin
            sum_start = 1'b1;
            state_d   = StSum;
          end
        end
      end
      StShift: begin
        if (ptr_nx < count_q) begin
          id_d[ptr_q]  = id_q[ptr_nx];
          qty_d[ptr_q] = qty_q[ptr_nx];
          ptr_d        = ptr_nx;
        end else begin
          id_d[count_m1]  = '0;
          qty_d[count_m1] = '0;
          count_d         = count_m1;
          sum_start       = 1'b1;
          state_d         = StSum;
        end
      end
      StSum: begin
        if (sum_done) begin
          total_d = sum_val;
          ack_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_basket_manager.sv
// Directed plus randomized bench for basket_manager against a queue-based basket model.
module tb_basket_manager;

  localparam int ID_W = 4, QTY_W = 4, PRICE_W = 8, TOTAL_W = 16;
  localparam int MaxItems = 12, MaxQty = 9;
  localparam int RespNone = 0, RespAck = 1, RespNack = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b1;
  logic               add_req = 1'b0, remove_req = 1'b0, clear_req = 1'b0;
  logic [ID_W-1:0]    sel_pid = '0, sel_idx = '0, rd_idx = '0;
  logic [PRICE_W-1:0] price_data;
  logic [ID_W-1:0]    price_addr, rd_pid, basket_num;
  logic [QTY_W-1:0]   rd_qty;
  logic               basket_empty, busy, ack, nack;
  logic [TOTAL_W-1:0] total;

  int n_checks = 0, n_pass = 0;
  int ack_seen = 0, nack_seen = 0;
  int price [16];
  int m_id[$], m_qty[$];
  int m_total = 0;

  basket_manager dut (
    .CLOCK            (clk),
    .RESET_N          (rst_n),
    .Enable           (enable),
    .AddReq           (add_req),
    .RemoveReq        (remove_req),
    .ClearReq         (clear_req),
    .SelProductID     (sel_pid),
    .SelBasketIdx     (sel_idx),
    .RdIdx            (rd_idx),
    .PriceData        (price_data),
    .PriceAddr        (price_addr),
    .RdProductID      (rd_pid),
    .RdQty            (rd_qty),
    .BasketProductNum (basket_num),
    .BasketEmpty      (basket_empty),
    .Total            (total),
    .Busy             (busy),
    .Ack              (ack),
    .Nack             (nack)
  );

  always #5 clk = ~clk;

  // Synchronous price ROM: data valid one cycle after the address.
  always @(posedge clk) price_data <= PRICE_W'(price[price_addr]);

  always @(negedge clk) begin
    if (ack) ack_seen++;
    if (nack) nack_seen++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model_sum();
    int s = 0;
    foreach (m_id[i]) s += m_qty[i] * price[m_id[i]];
    return s;
  endfunction

  function automatic int model_add(input int id);
    foreach (m_id[i]) begin
      if (m_id[i] == id) begin
        if (m_qty[i] == MaxQty) return RespNack;
        m_qty[i]++;
        m_total = model_sum();
        return RespAck;
      end
    end
    if (m_id.size() == MaxItems) return RespNack;
    m_id.push_back(id);
    m_qty.push_back(1);
    m_total = model_sum();
    return RespAck;
  endfunction

  function automatic int model_remove(input int idx);
    if (idx >= m_id.size()) return RespNack;
    m_qty[idx]--;
    if (m_qty[idx] == 0) begin
      m_id.delete(idx);
      m_qty.delete(idx);
    end
    m_total = model_sum();
    return RespAck;
  endfunction

  function automatic int model_clear();
    m_id.delete();
    m_qty.delete();
    m_total = 0;
    return RespAck;
  endfunction

  // Pulse a command for one cycle and wait (bounded) for Ack or Nack.
  task automatic do_cmd(input logic a, input logic r, input logic c, input int pid,
                        input int idx, input int limit, output int resp);
    int a0 = ack_seen, n0 = nack_seen;
    @(negedge clk);
    add_req = a; remove_req = r; clear_req = c;
    sel_pid = ID_W'(pid); sel_idx = ID_W'(idx);
    @(negedge clk);
    add_req = 1'b0; remove_req = 1'b0; clear_req = 1'b0;
    resp = RespNone;
    for (int i = 0; i < limit && resp == RespNone; i++) begin
      @(negedge clk); #1;
      if (ack_seen != a0) resp = RespAck;
      else if (nack_seen != n0) resp = RespNack;
    end
  endtask

  task automatic compare_all(input string tag);
    int n = m_id.size();
    check({tag, " empty"}, int'(basket_empty), int'(n == 0));
    check({tag, " num"}, int'(basket_num), (n == 0) ? 0 : n - 1);
    check({tag, " total"}, int'(total), m_total);
    check({tag, " busy"}, int'(busy), 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rd_idx = ID_W'(i);
      @(negedge clk);
      check($sformatf("%s rd_id[%0d]", tag, i), int'(rd_pid), (i < n) ? m_id[i] : 0);
      check($sformatf("%s rd_qty[%0d]", tag, i), int'(rd_qty), (i < n) ? m_qty[i] : 0);
    end
  endtask

  task automatic add_chk(input int id, input string tag);
    int r, e;
    e = model_add(id);
    do_cmd(1'b1, 1'b0, 1'b0, id, 0, 300, r);
    check({tag, " resp"}, r, e);
  endtask

  task automatic rem_chk(input int idx, input string tag);
    int r, e;
    e = model_remove(idx);
    do_cmd(1'b0, 1'b1, 1'b0, 0, idx, 300, r);
    check({tag, " resp"}, r, e);
  endtask

  task automatic clr_chk(input string tag);
    int r, e;
    e = model_clear();
    do_cmd(1'b0, 1'b0, 1'b1, 0, 0, 300, r);
    check({tag, " resp"}, r, e);
  endtask

  initial begin
    int r, a0, n0, op;
    for (int i = 0; i < 16; i++) price[i] = $urandom_range(0, 255);
    price[5] = 20;

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst ack", int'(ack), 0);
    check("rst nack", int'(nack), 0);
    check("rst price_addr", int'(price_addr), 0);
    compare_all("reset");

    // Same id twice merges into one entry.
    add_chk(5, "add5a");
    add_chk(5, "add5b");
    check("add5 total", int'(total), 40);
    compare_all("add5x2");

    // Fill to capacity, reject a new id, saturate one quantity.
    clr_chk("clr1");
    for (int i = 0; i < MaxItems; i++) add_chk(i, $sformatf("fill%0d", i));
    compare_all("full");
    add_chk(12, "full new id");
    for (int i = 0; i < MaxQty - 1; i++) add_chk(3, $sformatf("sat%0d", i));
    add_chk(3, "qty sat");
    compare_all("saturated");

    // Removal with compaction and bad index.
    clr_chk("clr2");
    add_chk(2, "b2"); add_chk(7, "b7");
    for (int i = 0; i < 3; i++) add_chk(4, "b4");
    rem_chk(0, "rem0");
    compare_all("after rem0");
    rem_chk(5, "rem bad");
    compare_all("after rem bad");

    // Clear wins over a simultaneous add; exactly one Ack.
    a0 = ack_seen;
    void'(model_clear());
    do_cmd(1'b1, 1'b0, 1'b1, 9, 0, 300, r);
    repeat (5) @(negedge clk);
    check("add+clr resp", r, RespAck);
    check("add+clr ack count", ack_seen - a0, 1);
    compare_all("add+clr");

    // Disabled requests are dropped silently.
    add_chk(6, "pre dis");
    enable = 1'b0;
    do_cmd(1'b1, 1'b0, 1'b0, 8, 0, 20, r);
    check("disabled resp", r, RespNone);
    enable = 1'b1;
    compare_all("disabled");

    // A second add while busy is dropped.
    a0 = ack_seen; n0 = nack_seen;
    @(negedge clk);
    add_req = 1'b1; sel_pid = 4'd10;
    @(negedge clk);
    sel_pid = 4'd11;
    #1 check("busy during add", int'(busy), 1);
    @(negedge clk);
    add_req = 1'b0;
    void'(model_add(10));
    repeat (60) @(negedge clk);
    check("busy add acks", ack_seen - a0, 1);
    check("busy add nacks", nack_seen - n0, 0);
    compare_all("busy add");

    // Randomized command mix.
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 11);
      if (op == 0) clr_chk($sformatf("rnd%0d clr", t));
      else if (op < 5) rem_chk($urandom_range(0, 13), $sformatf("rnd%0d rem", t));
      else add_chk($urandom_range(0, 13), $sformatf("rnd%0d add", t));
      if (t % 6 == 5) compare_all($sformatf("rnd%0d", t));
    end

    // Reset in the middle of a compaction.
    clr_chk("clr3");
    for (int i = 1; i <= 5; i++) add_chk(i, "pre shift");
    @(negedge clk);
    remove_req = 1'b1; sel_idx = 4'd0;
    @(negedge clk);
    remove_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst empty", int'(basket_empty), 1);
    check("midrst busy", int'(busy), 0);
    check("midrst total", int'(total), 0);
    void'(model_clear());
    @(negedge clk);
    rst_n = 1'b1;
    add_chk(1, "post rst add");
    compare_all("post rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
